// File: rtl/timing_sequencer.sv
// timing_sequencer - STOPPED/RUNNING sequencer with a programmable wrap point and registered one-hot timing outputs.
// COUNT, T, RUN and WRAP are all registered. T is decoded from the next-state count and run flag so it moves on the same edge as COUNT.
module timing_sequencer #(
  parameter  int N_STATES = 8,
  localparam int CW       = $clog2(N_STATES)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_inc,
  input  logic                i_clr,
  input  logic                i_load,
  input  logic [CW-1:0]       i_load_val,
  input  logic [CW-1:0]       i_last,
  output logic [CW-1:0]       o_count,
  output logic [N_STATES-1:0] o_t,
  output logic                o_run,
  output logic                o_wrap
);

  typedef enum logic {ST_STOPPED = 1'b0, ST_RUNNING = 1'b1} state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(N_STATES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       w_count_nxt;
  logic [N_STATES-1:0] r_t;
  logic [N_STATES-1:0] w_t_nxt;
  logic                r_wrap;
  logic                w_wrap_nxt;
  logic [CW-1:0]       w_lim;
  logic [CW-1:0]       w_load_sat;

  // LAST is clamped so a non-power-of-two N_STATES can never index past the top state.
  assign w_lim      = (i_last > MAX_CNT) ? MAX_CNT : i_last;
  assign w_load_sat = (i_load_val > w_lim) ? w_lim : i_load_val;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_STOPPED;
      r_count <= '0;
      r_t     <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_t     <= w_t_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_STOPPED: if (i_start && !i_stop) w_state_nxt = ST_RUNNING;
      ST_RUNNING: if (i_stop)             w_state_nxt = ST_STOPPED;
      default:                            w_state_nxt = ST_STOPPED;
    endcase
  end

  // Advance is gated by the current state, so INC with START does nothing and INC with STOP still counts.
  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_t_nxt     = '0;
    if (i_clr) begin
      w_count_nxt = '0;
    end else if (i_load) begin
      w_count_nxt = w_load_sat;
    end else if (i_inc && (r_state == ST_RUNNING)) begin
      if (r_count >= w_lim) begin
        w_count_nxt = '0;
        w_wrap_nxt  = 1'b1;
      end else begin
        w_count_nxt = r_count + 1'b1;
      end
    end
    if (w_state_nxt == ST_RUNNING) w_t_nxt[w_count_nxt] = 1'b1;
  end

  assign o_count = r_count;
  assign o_t     = r_t;
  assign o_run   = (r_state == ST_RUNNING);
  assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_timing_sequencer.sv
// tb_timing_sequencer - directed bench for timing_sequencer at N_STATES 8, 16 and 6 against a per-cycle arithmetic model.
module tb_timing_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n    = 1'b0;
  logic       start    = 1'b0;
  logic       stop     = 1'b0;
  logic       inc      = 1'b0;
  logic       clr      = 1'b0;
  logic       load     = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] last     = 4'd7;

  logic [2:0]  cnt8,  cnt6;
  logic [3:0]  cnt16;
  logic [7:0]  t8;
  logic [15:0] t16;
  logic [5:0]  t6;
  logic        run8, run16, run6, wrap8, wrap16, wrap6;

  timing_sequencer #(.N_STATES(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_inc(inc),
    .i_clr(clr), .i_load(load), .i_load_val(load_val[2:0]), .i_last(last[2:0]),
    .o_count(cnt8), .o_t(t8), .o_run(run8), .o_wrap(wrap8));

  timing_sequencer #(.N_STATES(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_inc(inc),
    .i_clr(clr), .i_load(load), .i_load_val(load_val), .i_last(last),
    .o_count(cnt16), .o_t(t16), .o_run(run16), .o_wrap(wrap16));

  timing_sequencer #(.N_STATES(6)) dut6 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_inc(inc),
    .i_clr(clr), .i_load(load), .i_load_val(load_val[2:0]), .i_last(last[2:0]),
    .o_count(cnt6), .o_t(t6), .o_run(run6), .o_wrap(wrap6));

  localparam int NS [3] = '{8, 16, 6};

  int d_cnt [3];
  int d_t   [3];
  bit d_run [3];
  bit d_wrap[3];
  assign d_cnt[0] = int'(cnt8);   assign d_t[0] = int'(t8);   assign d_run[0] = run8;  assign d_wrap[0] = wrap8;
  assign d_cnt[1] = int'(cnt16);  assign d_t[1] = int'(t16);  assign d_run[1] = run16; assign d_wrap[1] = wrap16;
  assign d_cnt[2] = int'(cnt6);   assign d_t[2] = int'(t6);   assign d_run[2] = run6;  assign d_wrap[2] = wrap6;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: count state as plain integers, limit = min(LAST, N-1).
  int m_cnt [3];
  bit m_run [3];
  bit m_wrap[3];

  function automatic int lim_of(input int n);
    return (int'(last) < n - 1) ? int'(last) : n - 1;
  endfunction

  function automatic int cnt_next(input int n, input int c, input bit r);
    int lim;
    lim = lim_of(n);
    if (clr)                return 0;
    if (load)               return (int'(load_val) < lim) ? int'(load_val) : lim;
    if (inc && r)           return (c >= lim) ? 0 : c + 1;
    return c;
  endfunction

  function automatic bit wrap_next(input int n, input int c, input bit r);
    return !clr && !load && inc && r && (c >= lim_of(n));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i]  <= 0;
        m_run[i]  <= 1'b0;
        m_wrap[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i]  <= cnt_next(NS[i], m_cnt[i], m_run[i]);
        m_wrap[i] <= wrap_next(NS[i], m_cnt[i], m_run[i]);
        m_run[i]  <= stop ? 1'b0 : (m_run[i] | start);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_cnt_n%0d", NS[i]),  d_cnt[i],  m_cnt[i]);
        chk($sformatf("model_run_n%0d", NS[i]),  int'(d_run[i]),  int'(m_run[i]));
        chk($sformatf("model_wrap_n%0d", NS[i]), int'(d_wrap[i]), int'(m_wrap[i]));
        chk($sformatf("model_t_n%0d", NS[i]),    d_t[i], m_run[i] ? (1 << m_cnt[i]) : 0);
      end
    end
  end

  task automatic lit8(input string tag, input int c, input int t, input int r, input int w);
    chk({tag, "_count"}, int'(cnt8), c);
    chk({tag, "_t"},     int'(t8),   t);
    chk({tag, "_run"},   int'(run8), r);
    chk({tag, "_wrap"},  int'(wrap8), w);
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    nclk(2);
    lit8("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    start = 1'b1; nclk(1); start = 1'b0;
    lit8("start", 0, 1, 1, 0);
    inc = 1'b1; nclk(7);
    lit8("walk7", 7, 128, 1, 0);
    chk("n6_clamped_walk", int'(cnt6), 1);
    nclk(1); lit8("wrap7", 0, 1, 1, 1);
    nclk(1); lit8("after_wrap", 1, 2, 1, 0);
    inc = 1'b0;

    last = 4'd3; clr = 1'b1; nclk(1); clr = 1'b0;
    lit8("clr", 0, 1, 1, 0);
    inc = 1'b1; nclk(2); lit8("last3_at2", 2, 4, 1, 0);
    clr = 1'b1; nclk(1); clr = 1'b0;
    lit8("clr_beats_inc", 0, 1, 1, 0);
    nclk(3); lit8("last3_top", 3, 8, 1, 0);
    nclk(1); lit8("last3_wrap", 0, 1, 1, 1);
    inc = 1'b0;

    stop = 1'b1; nclk(1); stop = 1'b0;
    lit8("stop", 0, 0, 0, 0);
    last = 4'd7; load_val = 4'd5; load = 1'b1; nclk(1); load = 1'b0;
    lit8("load_stopped", 5, 0, 0, 0);
    inc = 1'b1; nclk(1); inc = 1'b0;
    lit8("inc_stopped", 5, 0, 0, 0);
    start = 1'b1; nclk(1); start = 1'b0;
    lit8("start_loaded", 5, 32, 1, 0);
    last = 4'd4; load_val = 4'd6; load = 1'b1; nclk(1); load = 1'b0;
    lit8("load_clamp", 4, 16, 1, 0);

    stop = 1'b1; nclk(1); stop = 1'b0;
    start = 1'b1; stop = 1'b1; nclk(1); start = 1'b0; stop = 1'b0;
    lit8("start_stop", 4, 0, 0, 0);
    last = 4'd7; load_val = 4'd2; load = 1'b1; nclk(1); load = 1'b0;
    start = 1'b1; nclk(1); start = 1'b0;
    lit8("run_at2", 2, 4, 1, 0);
    stop = 1'b1; inc = 1'b1; nclk(1); stop = 1'b0; inc = 1'b0;
    lit8("stop_inc", 3, 0, 0, 0);
    start = 1'b1; inc = 1'b1; nclk(1); start = 1'b0; inc = 1'b0;
    lit8("start_inc", 3, 8, 1, 0);
    last = 4'd1; inc = 1'b1; nclk(1); inc = 1'b0;
    lit8("last_lowered", 0, 1, 1, 1);
    last = 4'd7;

    load_val = 4'd6; load = 1'b1; nclk(1); load = 1'b0;
    lit8("pre_reset", 6, 64, 1, 0);
    #2 rst_n = 1'b0;
    #1 lit8("async_reset", 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    start = 1'b1; nclk(1); start = 1'b0;
    lit8("restart", 0, 1, 1, 0);

    last = 4'd0; inc = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nclk(1);
      chk("n16_lim0_count", int'(cnt16), 0);
      chk("n16_lim0_t",     int'(t16),   1);
      chk("n16_lim0_wrap",  int'(wrap16), 1);
    end
    inc = 1'b0; nclk(1);
    chk("n16_lim0_wrap_end", int'(wrap16), 0);

    nclk(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
